// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: branch funct3 encodings, 2-bit counter
// type and its saturating update.
package bp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    ctr_t r;
    if (taken) r = (c == CTR_ST)  ? CTR_ST  : c + 2'd1;
    else       r = (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/br_resolve.sv
// EX-stage branch resolution: turns funct3 plus comparator flags into the
// actual outcome, mispredict flag and the corrected next PC. Purely combinational.
module br_resolve
  import bp_pkg::*;
(
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        br_less,
  input  logic        br_equal,
  output logic        br_unsigned,
  output logic        resolve_active,
  output logic        ex_taken,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  logic cond_taken;

  always_comb begin
    cond_taken = 1'b0;
    case (ex_funct3)
      F3_BEQ:           cond_taken = br_equal;
      F3_BNE:           cond_taken = !br_equal;
      F3_BLT, F3_BLTU:  cond_taken = br_less;
      F3_BGE, F3_BGEU:  cond_taken = !br_less;
      default:          cond_taken = 1'b0;
    endcase
  end

  assign br_unsigned    = ex_funct3[1];
  assign resolve_active = ex_valid && (ex_is_branch || ex_is_jump);
  assign ex_taken       = resolve_active && (ex_is_jump || cond_taken);

  // A taken branch is also wrong when it went to a stale BTB target.
  assign mispredict  = resolve_active &&
                       ((ex_taken && (!ex_pred_taken || (ex_pred_target != ex_target))) ||
                        (!ex_taken && ex_pred_taken));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT with tagged BTB: zero-latency IF prediction, EX resolution,
// table update on the resolving edge (no IF bypass) and saturating perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        br_unsigned,
  input  logic        br_less,
  input  logic        br_equal,
  output logic        ex_taken,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] cnt_branch,
  output logic [31:0] cnt_mispred
);

  localparam int DEPTH = 1 << IDX_W;

  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  ctr_t             ctr_q   [DEPTH];
  logic [31:0]      btb_q   [DEPTH];

  logic [31:0] cnt_branch_q,  cnt_branch_d;
  logic [31:0] cnt_mispred_q, cnt_mispred_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, resolve_active;
  ctr_t             ctr_d;
  logic [31:0]      btb_d;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? btb_q[if_idx] : if_pc + 32'd4;

  br_resolve u_resolve (
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .br_less        (br_less),
    .br_equal       (br_equal),
    .br_unsigned    (br_unsigned),
    .resolve_active (resolve_active),
    .ex_taken       (ex_taken),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
  );

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A miss allocates fresh; a not-taken hit keeps the old target.
  always_comb begin
    ctr_d = ctr_q[ex_idx];
    btb_d = btb_q[ex_idx];
    if (ex_is_jump) begin
      ctr_d = CTR_ST;
      btb_d = ex_target;
    end else if (ex_hit) begin
      ctr_d = sat_update(ctr_q[ex_idx], ex_taken);
      if (ex_taken) btb_d = ex_target;
    end else begin
      ctr_d = ex_taken ? CTR_WT : CTR_WNT;
      btb_d = ex_target;
    end
  end

  always_comb begin
    cnt_branch_d  = cnt_branch_q;
    cnt_mispred_d = cnt_mispred_q;
    if (resolve_active && (cnt_branch_q != 32'hFFFF_FFFF))
      cnt_branch_d = cnt_branch_q + 32'd1;
    if (mispredict && (cnt_mispred_q != 32'hFFFF_FFFF))
      cnt_mispred_d = cnt_mispred_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
        btb_q[i]   <= '0;
      end
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      if (resolve_active) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        ctr_q[ex_idx]   <= ctr_d;
        btb_q[ex_idx]   <= btb_d;
      end
      cnt_branch_q  <= cnt_branch_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign cnt_branch  = cnt_branch_q;
  assign cnt_mispred = cnt_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: table of resolve vectors, then
// hand-written learning, aliasing, same-cycle and reset sequences.
module tb_branch_predictor;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_is_jump;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_pred_taken;
  logic        br_unsigned, br_less, br_equal;
  logic        ex_taken, mispredict;
  logic [31:0] redirect_pc, cnt_branch, cnt_mispred;

  branch_predictor dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .br_unsigned    (br_unsigned),
    .br_less        (br_less),
    .br_equal       (br_equal),
    .ex_taken       (ex_taken),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .cnt_branch     (cnt_branch),
    .cnt_mispred    (cnt_mispred)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        vld, br, jmp;
    logic [2:0]  f3;
    logic        less, eq;
    logic [31:0] pc, tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_taken, e_misp;
    logic [31:0] e_redir;
    logic        e_uns;
  } vec_t;

  vec_t vecs[$];
  int n_pass = 0;
  int n_total = 0;
  int exp_br = 0;
  int exp_mp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic add_vec(input logic vld, br, jmp, input logic [2:0] f3, input logic less, eq,
                         input logic [31:0] pc, tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic e_taken, e_misp, input logic [31:0] e_redir, input logic e_uns);
    vec_t v;
    v.vld = vld; v.br = br; v.jmp = jmp; v.f3 = f3; v.less = less; v.eq = eq;
    v.pc = pc; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
    v.e_taken = e_taken; v.e_misp = e_misp; v.e_redir = e_redir; v.e_uns = e_uns;
    vecs.push_back(v);
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_funct3 = 3'b000;
    ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    br_less = 1'b0; br_equal = 1'b0;
  endtask

  // One resolve held across exactly one rising edge; outputs checked before it.
  task automatic resolve(input string nm, input logic br, jmp, input logic [2:0] f3,
                         input logic less, eq, input logic [31:0] pc, tgt,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic e_taken, e_misp, input logic [31:0] e_redir);
    @(negedge i_clk);
    ex_valid = 1'b1; ex_is_branch = br; ex_is_jump = jmp; ex_funct3 = f3;
    br_less = less; br_equal = eq; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    chk({nm, ".taken"}, ex_taken, e_taken);
    chk({nm, ".misp"}, mispredict, e_misp);
    chk({nm, ".redir"}, redirect_pc, e_redir);
    exp_br++;
    if (e_misp) exp_mp++;
  endtask

  task automatic lookup(input string nm, input logic [31:0] pc, input logic e_pt,
                        input logic [31:0] e_tgt);
    @(negedge i_clk);
    idle_ex();
    if_pc = pc;
    #1;
    chk({nm, ".pred_taken"}, pred_taken, e_pt);
    chk({nm, ".pred_target"}, pred_target, e_tgt);
  endtask

  initial begin
    i_reset = 1'b1;
    if_pc = 32'h100;
    idle_ex();

    //       vld br jmp f3      lt eq pc       tgt      ptk ptgt     taken misp redir   uns
    add_vec(1, 1, 0, 3'b000, 0, 1, 32'h100, 32'h140, 0, 32'h104, 1, 1, 32'h140, 0);
    add_vec(1, 1, 0, 3'b000, 0, 0, 32'h100, 32'h140, 0, 32'h104, 0, 0, 32'h104, 0);
    add_vec(1, 1, 0, 3'b001, 0, 0, 32'h300, 32'h280, 1, 32'h280, 1, 0, 32'h280, 0);
    add_vec(1, 1, 0, 3'b100, 1, 0, 32'h310, 32'h380, 1, 32'h390, 1, 1, 32'h380, 0);
    add_vec(1, 1, 0, 3'b101, 1, 0, 32'h320, 32'h380, 1, 32'h380, 0, 1, 32'h324, 0);
    add_vec(1, 1, 0, 3'b101, 0, 0, 32'h330, 32'h3a0, 0, 32'h334, 1, 1, 32'h3a0, 0);
    add_vec(1, 1, 0, 3'b110, 0, 0, 32'h200, 32'h240, 1, 32'h240, 0, 1, 32'h204, 1);
    add_vec(1, 1, 0, 3'b111, 0, 1, 32'h204, 32'h100, 0, 32'h208, 1, 1, 32'h100, 1);
    add_vec(1, 1, 0, 3'b010, 1, 1, 32'h500, 32'h540, 0, 32'h504, 0, 0, 32'h504, 1);
    add_vec(1, 1, 0, 3'b011, 1, 1, 32'h504, 32'h540, 1, 32'h540, 0, 1, 32'h508, 1);
    add_vec(1, 0, 1, 3'b000, 0, 0, 32'h400, 32'h480, 1, 32'h480, 1, 0, 32'h480, 0);
    add_vec(1, 0, 1, 3'b111, 1, 0, 32'h404, 32'h600, 0, 32'h408, 1, 1, 32'h600, 1);
    add_vec(0, 1, 0, 3'b000, 0, 1, 32'h100, 32'h140, 1, 32'h140, 0, 0, 32'h104, 0);
    add_vec(1, 0, 0, 3'b001, 0, 0, 32'h110, 32'h150, 1, 32'h150, 0, 0, 32'h114, 0);

    @(negedge i_clk);
    i_reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge i_clk);
      ex_valid = vecs[i].vld; ex_is_branch = vecs[i].br; ex_is_jump = vecs[i].jmp;
      ex_funct3 = vecs[i].f3; br_less = vecs[i].less; br_equal = vecs[i].eq;
      ex_pc = vecs[i].pc; ex_target = vecs[i].tgt;
      ex_pred_taken = vecs[i].ptk; ex_pred_target = vecs[i].ptgt;
      #1;
      chk($sformatf("vec%0d.taken", i), ex_taken, vecs[i].e_taken);
      chk($sformatf("vec%0d.misp", i), mispredict, vecs[i].e_misp);
      chk($sformatf("vec%0d.redir", i), redirect_pc, vecs[i].e_redir);
      chk($sformatf("vec%0d.uns", i), br_unsigned, vecs[i].e_uns);
    end

    // Fresh start for the learning sequences.
    @(negedge i_clk);
    idle_ex();
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;

    lookup("rst", 32'h100, 1'b0, 32'h104);
    chk("rst.cnt_branch", cnt_branch, 32'd0);
    chk("rst.cnt_mispred", cnt_mispred, 32'd0);

    resolve("beq", 1, 0, 3'b000, 0, 1, 32'h100, 32'h140, 0, 32'h104, 1, 1, 32'h140);
    chk("beq.uns", br_unsigned, 1'b0);
    lookup("beq_learn", 32'h100, 1'b1, 32'h140);

    // 0x200 shares index 0 with 0x100 under a different tag.
    resolve("bltu_alloc", 1, 0, 3'b110, 1, 0, 32'h200, 32'h240, 0, 32'h204, 1, 1, 32'h240);
    lookup("bltu_learn", 32'h200, 1'b1, 32'h240);
    lookup("alias_miss", 32'h100, 1'b0, 32'h104);
    resolve("bltu_nt", 1, 0, 3'b110, 0, 0, 32'h200, 32'h240, 1, 32'h240, 0, 1, 32'h204);
    chk("bltu_nt.uns", br_unsigned, 1'b1);
    lookup("bltu_dec", 32'h200, 1'b0, 32'h204);

    // Counter path 10,11,11,11,10,01 seen through the taken bit.
    for (int i = 0; i < 6; i++) begin
      logic tk;
      logic exp_pt;
      tk = (i < 4);
      exp_pt = (i < 5);
      resolve($sformatf("bne%0d", i), 1, 0, 3'b001, 0, !tk, 32'h300, 32'h380, 0, 32'h304,
              tk, tk, tk ? 32'h380 : 32'h304);
      lookup($sformatf("bne%0d_lk", i), 32'h300, exp_pt, exp_pt ? 32'h380 : 32'h304);
    end

    // JAL update and IF lookup of the same entry in the same cycle.
    @(negedge i_clk);
    if_pc = 32'h400;
    resolve("jal", 0, 1, 3'b000, 0, 0, 32'h400, 32'h480, 0, 32'h404, 1, 1, 32'h480);
    chk("jal_same_cycle.pred_taken", pred_taken, 1'b0);
    chk("jal_same_cycle.pred_target", pred_target, 32'h404);
    lookup("jal_learn", 32'h400, 1'b1, 32'h480);
    resolve("jal_nt1", 1, 0, 3'b000, 0, 0, 32'h400, 32'h480, 1, 32'h480, 0, 1, 32'h404);
    lookup("jal_ctr10", 32'h400, 1'b1, 32'h480);
    resolve("jal_nt2", 1, 0, 3'b000, 0, 0, 32'h400, 32'h480, 1, 32'h480, 0, 1, 32'h404);
    lookup("jal_ctr01", 32'h400, 1'b0, 32'h404);

    chk("cnt_branch", cnt_branch, 32'(exp_br));
    chk("cnt_mispred", cnt_mispred, 32'(exp_mp));

    // Reset mid-run: lookup re-checked while reset is still asserted.
    lookup("pre_reset", 32'h300, 1'b0, 32'h304);
    resolve("pre_reset_bne", 1, 0, 3'b001, 0, 0, 32'h300, 32'h380, 0, 32'h304, 1, 1, 32'h380);
    lookup("pre_reset_learn", 32'h300, 1'b1, 32'h380);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("mid_rst.cnt_branch", cnt_branch, 32'd0);
    chk("mid_rst.cnt_mispred", cnt_mispred, 32'd0);
    chk("mid_rst.pred_taken", pred_taken, 1'b0);
    chk("mid_rst.pred_target", pred_target, 32'h304);
    @(negedge i_clk);
    i_reset = 1'b0;
    lookup("post_rst_400", 32'h400, 1'b0, 32'h404);
    lookup("post_rst_300", 32'h300, 1'b0, 32'h304);
    chk("post_rst.cnt_branch", cnt_branch, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
